adc_capture_avg: RTL
====================

Name: adc_capture_avg

Overview:
Parametrised next-generation ADC front end for the acoustic carrier board. It generates the ADC sample clock from SYS_CLK and captures ADC_D/ADC_DTR at a fixed phase. It optionally averages 2^AVG_LOG2 accepted samples (boxcar decimation) and presents results on a valid/ready stream with sticky overrun detection. It sits between the ADC pins and the downstream acoustic processing pipeline.

Parameters:
DATA_W, 10, ADC sample width in bits.
CLK_DIV, 4, SYS_CLK cycles per ADC_CLK period; must be even and >= 2.
AVG_LOG2, 0, log2 of the samples averaged per output; legal range 0..4, where 0 means passthrough.

Ports:
SYS_CLK  in  1  system clock; the only clock in the block.
RESET  in  1  asynchronous, active-high reset.
ENABLE  in  1  1 = run the ADC clock and capture samples.
ADC_CLK  out  1  registered ADC sample clock.
ADC_DTR  in  1  ADC data-ready qualifier.
ADC_D  in  DATA_W  ADC data bus.
APP_DATA  out  DATA_W  averaged sample.
APP_DATA_VALID  out  1  APP_DATA holds a valid result.
APP_DATA_READY  in  1  downstream accepts the result.
OVERRUN  out  1  sticky flag: a result was dropped.
CLR_OVERRUN  in  1  clears OVERRUN.

Behaviour:
- Clocking and reset: one clock, SYS_CLK. RESET is asynchronous and active-high. While RESET=1: ADC_CLK=0, APP_DATA=0, APP_DATA_VALID=0, OVERRUN=0, and the divider, accumulator and sample count are all 0.
- Divider: counter c runs 0..CLK_DIV-1 and wraps to 0. It advances each cycle ENABLE=1. While ENABLE=0 it is held at 0.
- ADC_CLK is a register output. It is 1 in cycles where c < CLK_DIV/2 and ENABLE was 1 at the previous edge; otherwise it is 0. Resulting period = CLK_DIV SYS_CLK cycles at 50% duty.
- Capture strobe: the edge ending a cycle with c == CLK_DIV-1 (the last low phase, before ADC_CLK rises). ADC_D and ADC_DTR are registered on that edge only.
- Sample accept: a captured sample is accepted only if the captured ADC_DTR = 1. Otherwise it is discarded, and the accumulator and count are unchanged.
- Averaging:
  - Accumulator width = DATA_W+AVG_LOG2, unsigned. No overflow is possible.
  - The count increments on each accepted sample.
  - On the 2^AVG_LOG2-th sample: result = (acc + sample) >> AVG_LOG2, truncated. The accumulator and count then clear.
- Latency: a result is registered at the edge after its final capture edge, so APP_DATA_VALID rises 1 SYS_CLK cycle after that capture. With AVG_LOG2=0 every accepted sample produces a result.
- Output handshake:
  - Transfer occurs on an edge with VALID=1 and READY=1.
  - APP_DATA is held stable while VALID=1 and READY=0.
  - VALID drops after a transfer unless a new result loads on the same edge; in that case the new data loads and VALID stays 1.
- Overrun:
  - A new result arriving while VALID=1 and READY=0 is dropped. The old data is kept and OVERRUN is set.
  - OVERRUN stays set until CLR_OVERRUN=1. If a set and a clear occur on the same edge, set wins.
- ENABLE 1->0:
  - The divider freezes to 0 and ADC_CLK=0 from the next edge.
  - Accumulator and count clear, so a partial average is discarded.
  - The output register and its handshake continue; a pending result stays until consumed.
- ENABLE 0->1: c starts at 0 and ADC_CLK rises on the next edge. The first capture happens CLK_DIV edges later.
- RESET mid-operation: immediate asynchronous clear of all state. There is no partial output after reset.

Test Plan:
- Passthrough: CLK_DIV=4, AVG_LOG2=0, READY=1, ADC model increments ADC_D on each ADC_CLK rise -> ADC_CLK period 80 ns at 50 MHz. APP_DATA gives consecutive values 1,2,3,... with VALID pulsing once per 4 SYS_CLK cycles.
- Averaging: AVG_LOG2=2, samples 4,8,12,17 -> APP_DATA=10 (41>>2, truncated) as a single VALID pulse. The next group 0,0,0,3 -> APP_DATA=0.
- DTR gating: AVG_LOG2=1, captures (DTR,D) = (1,6), (0,100), (1,10) -> APP_DATA=8. The sample 100 never contributes.
- Backpressure: AVG_LOG2=0, READY=0 for 3 captures of 5,6,7 -> APP_DATA stays 5 and OVERRUN=1. Raise READY -> 5 is transferred. Pulse CLR_OVERRUN -> OVERRUN=0. Assert CLR_OVERRUN on the same edge as a new drop -> OVERRUN stays 1.
- ENABLE drop: AVG_LOG2=2, drop ENABLE after 2 accepted samples -> ADC_CLK low the next cycle and no VALID. Re-enable and feed 4 samples of 20 -> APP_DATA=20, with no contribution from the old partial sum.
- Reset mid-run: assert RESET asynchronously between clock edges while VALID=1 -> all outputs 0 immediately. After release with ENABLE=1, the first capture occurs CLK_DIV edges later.

Source files
------------

// File: rtl/adc_capture_avg.sv
// ADC front end: divided sample clock, fixed-phase capture, boxcar averaging,
// and a valid/ready result register with sticky overrun.
module adc_capture_avg #(
    parameter int DATA_W   = 10,
    parameter int CLK_DIV  = 4,
    parameter int AVG_LOG2 = 0
) (
    input  logic              SYS_CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    output logic              ADC_CLK,
    input  logic              ADC_DTR,
    input  logic [DATA_W-1:0] ADC_D,
    output logic [DATA_W-1:0] APP_DATA,
    output logic              APP_DATA_VALID,
    input  logic              APP_DATA_READY,
    output logic              OVERRUN,
    input  logic              CLR_OVERRUN
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic              strobe;

    logic [DATA_W-1:0] cap_d;
    logic              cap_dtr;
    logic              cap_vld;

    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ACC_W-1:0]  sum;
    logic              take;
    logic              last;
    logic              res_vld;
    logic [DATA_W-1:0] res_data;
    logic              drop;

    always_comb begin
        div_d = '0;
        if (ENABLE && (div_q != DIV_LAST)) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Capture on the edge that ends the last low phase, just as ADC_CLK rises.
    assign strobe = ENABLE && (div_q == DIV_LAST);

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            div_q   <= '0;
            ADC_CLK <= 1'b0;
        end else begin
            div_q   <= div_d;
            ADC_CLK <= ENABLE && (div_d < DIV_HALF);
        end
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            cap_d   <= '0;
            cap_dtr <= 1'b0;
            cap_vld <= 1'b0;
        end else begin
            cap_vld <= strobe;
            if (strobe) begin
                cap_d   <= ADC_D;
                cap_dtr <= ADC_DTR;
            end
        end
    end

    assign sum      = acc_q + ACC_W'(cap_d);
    assign take     = ENABLE && cap_vld && cap_dtr;
    assign last     = (cnt_q == CNT_LAST);
    assign res_vld  = take && last;
    assign res_data = DATA_W'(sum >> AVG_LOG2);

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (!ENABLE) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            if (last) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign drop = res_vld && APP_DATA_VALID && !APP_DATA_READY;

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            APP_DATA       <= '0;
            APP_DATA_VALID <= 1'b0;
            OVERRUN        <= 1'b0;
        end else begin
            if (res_vld) begin
                if (!APP_DATA_VALID || APP_DATA_READY) begin
                    APP_DATA       <= res_data;
                    APP_DATA_VALID <= 1'b1;
                end
            end else if (APP_DATA_READY) begin
                APP_DATA_VALID <= 1'b0;
            end
            // A drop on the same edge as a clear leaves the flag set.
            OVERRUN <= drop || (OVERRUN && !CLR_OVERRUN);
        end
    end

endmodule
